serv_irq_ctrl: RTL

//  Machine-level interrupt controller in front of the bit-serial CSR/trap datapath.
//  - Collects software (msip), timer (mtip) and external (meip) interrupt lines.
//  - Masks them with mstatus.MIE and the mie bits, and selects a winner by fixed priority.
//  - Raises a request/ack handshake to the core state machine.
//  - Streams the frozen exception code W bits per cycle into mcause during trap entry.

---
 rtl/serv_irq_pkg.sv | 27 ++
 rtl/serv_irq_sync.sv | 25 ++
 rtl/serv_irq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/serv_irq_pkg.sv
`default_nettype none
// serv_irq_pkg: state encoding, cause codes and mie bit positions for serv_irq_ctrl.
package serv_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TRAP = 2'd2
  } irq_state_t;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MIE_MSIE = 0;
  localparam int MIE_MTIE = 1;
  localparam int MIE_MEIE = 2;

  // Fixed priority MEI > MSI > MTI; only meaningful when at least one bit is set.
  function automatic logic [3:0] irq_cause(input logic [2:0] pend);
    if (pend[MIE_MEIE])      return CAUSE_MEI;
    else if (pend[MIE_MSIE]) return CAUSE_MSI;
    else                     return CAUSE_MTI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serv_irq_sync.sv
`default_nettype none
// serv_irq_sync: async-reset flop chain bringing the external interrupt level into the clk domain.
module serv_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/serv_irq_ctrl.sv
`default_nettype none
// serv_irq_ctrl: machine-level irq masking, priority, req/ack handshake and serial mcause stream.
// Optional external interrupt path enabled by defining SERV_IRQ_CTRL_EXT_EN.
module serv_irq_ctrl
  import serv_irq_pkg::*;
#(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_msip,
  input  logic         i_mtip,
  input  logic         i_meip,
  input  logic         i_mstatus_mie,
  input  logic [2:0]   i_mie,
  input  logic         i_irq_ack,
  input  logic         i_trap_done,
  input  logic         i_en,
  input  logic         i_cnt0to3,
  input  logic [1:0]   i_cnt_lo,
  input  logic         i_cnt_done,
  output logic         o_irq_req,
  output logic [W-1:0] o_mcause,
  output logic         o_busy
);

  irq_state_t   state;
  logic [3:0]   cause;
  logic         meip_s;
  logic [2:0]   pend;
  logic [3:0]   win;
  logic [W-1:0] cause_bits;

`ifdef SERV_IRQ_CTRL_EXT_EN
  serv_irq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_meip_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_meip),
    .q     (meip_s)
  );
`else
  logic unused_ext;
  assign unused_ext = i_meip;
  assign meip_s     = 1'b0;
`endif

  assign pend = {meip_s & i_mie[MIE_MEIE],
                 i_mtip & i_mie[MIE_MTIE],
                 i_msip & i_mie[MIE_MSIE]} & {3{i_mstatus_mie}};
  assign win  = irq_cause(pend);

  // Code tracks the best pending source until ack, then stays frozen for the whole trap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cause     <= '0;
      o_irq_req <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            state     <= REQ;
            cause     <= win;
            o_irq_req <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        REQ: begin
          if (i_irq_ack) begin
            state     <= TRAP;
            o_irq_req <= 1'b0;
          end else if (!(|pend)) begin
            state     <= IDLE;
            o_irq_req <= 1'b0;
            o_busy    <= 1'b0;
          end else begin
            cause <= win;
          end
        end
        TRAP: begin
          if (i_trap_done) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          o_irq_req <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (W == 1) begin : g_serial
      assign cause_bits = cause[i_cnt_lo];
    end else begin : g_nibble
      logic [1:0] unused_cnt_lo;
      assign unused_cnt_lo = i_cnt_lo;
      assign cause_bits    = cause[W-1:0];
    end
  endgenerate

  // The MSB of the last datapath beat carries mcause[31], which is always 1 for interrupts.
  always_comb begin
    o_mcause = '0;
    if (state == TRAP && i_en) begin
      if (i_cnt0to3) o_mcause = cause_bits;
      if (i_cnt_done) o_mcause[W-1] = 1'b1;
    end
  end

endmodule
`default_nettype wire
